alu_op_dispatcher: RTL

- Parametrised, registered successor of the 2-to-4 ALU op-select decoder.
- Accepts one op-select command per handshake and drives a one-hot ALU block enable for a programmable number of cycles.
- Ends each op with a one-cycle done pulse; supports abort.
- Sits between the control unit and the ALU function blocks, one enable line per ALU block.

---
 rtl/alu_dispatch_pkg.sv | 14 +
 rtl/onehot_decoder.sv | 16 +
 rtl/alu_op_dispatcher.sv | 99 +++++++++
 3 files changed

// File: rtl/alu_dispatch_pkg.sv
// rtl/alu_dispatch_pkg.sv - shared types and defaults for the ALU op dispatcher
package alu_dispatch_pkg;

  // Dispatcher control states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int SEL_W_DEF = 2;
  localparam int CNT_W_DEF = 4;

endpackage

// File: rtl/onehot_decoder.sv
// rtl/onehot_decoder.sv - combinational select-to-one-hot decoder with enable
module onehot_decoder #(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
  output logic [(2**SEL_W)-1:0] y
);

  // Drive exactly one line when enabled, none otherwise
  always_comb begin
    y = '0;
    if (en) y[sel] = 1'b1;
  end

endmodule

// File: rtl/alu_op_dispatcher.sv
// rtl/alu_op_dispatcher.sv - registered one-hot ALU block enable with programmable hold
module alu_op_dispatcher
  import alu_dispatch_pkg::*;
#(
  parameter int  SEL_W   = SEL_W_DEF,
  parameter int  CNT_W   = CNT_W_DEF,
  localparam int NUM_OPS = 2**SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SEL_W-1:0]   sel,
  input  logic               enable,
  output logic               cmd_ready,
  input  logic [CNT_W-1:0]   op_len,
  input  logic               abort,
  output logic [NUM_OPS-1:0] y,
  output logic               busy,
  output logic               done
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [SEL_W-1:0]   sel_q, sel_nxt;
  logic [NUM_OPS-1:0] y_q, y_nxt;
  logic               done_q, done_nxt;

  // The y register is always loaded from the decoder, so it can never be
  // multi-hot. In IDLE the decoder looks at the incoming command; while
  // ACTIVE it re-decodes the latched select to hold the enable line.
  logic [SEL_W-1:0]   dec_sel;
  logic               dec_en;

  onehot_decoder #(.SEL_W(SEL_W)) u_dec (
    .sel (dec_sel),
    .en  (dec_en),
    .y   (y_nxt)
  );

  // Next-state, counter and decoder control
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sel_nxt   = sel_q;
    done_nxt  = 1'b0;
    dec_sel   = sel_q;
    dec_en    = 1'b0;
    case (state)
      IDLE: begin
        dec_sel = sel;
        dec_en  = enable;
        if (enable) begin
          sel_nxt   = sel;
          cnt_nxt   = (op_len == '0) ? CNT_W'(1) : op_len;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_W'(1)) begin
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else begin
          dec_en  = 1'b1;
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      sel_q  <= '0;
      y_q    <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      sel_q  <= sel_nxt;
      y_q    <= y_nxt;
      done_q <= done_nxt;
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign y         = y_q;
  assign done      = done_q;

endmodule
